draw_bag: RTL and testbench

- Downstream consumer of the bag motion controller's xpos/ypos.
- Overlays a 48x48 bag sprite onto the VGA timing/RGB stream, using a synchronous image ROM.
- Position is latched once per frame, at the start of vertical blanking, so a frame never tears.
- Sits in the video pipeline between the background/player draw stage and the VGA output register.

---
 rtl/draw_bag.sv | 117 +++++++++++
 tb/tb_draw_bag.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_bag.sv
// Overlays a WIDTHxHEIGHT sprite from a synchronous image ROM onto the VGA stream.
// The sprite position is captured once per frame at the rising edge of vertical blanking.
module draw_bag #(
    parameter int          WIDTH       = 48,
    parameter int          HEIGHT      = 48,
    parameter logic [11:0] TRANSPARENT = 12'hF0F,
    parameter logic [11:0] OFFSCREEN   = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [11:0] rgb_pixel,
    output logic [11:0] pixel_addr,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic        vblnk_d;
    logic [11:0] x_lat;
    logic [11:0] y_lat;

    logic [12:0] h_ext, v_ext, x_ext, y_ext;
    logic        in_win;
    logic [5:0]  col, row;

    logic [10:0] hcount_1, vcount_1;
    logic        hsync_1, vsync_1, hblnk_1, vblnk_1;
    logic [11:0] rgb_1;
    logic        in_win_1;

    // Position only moves on the blanking edge so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            x_lat   <= OFFSCREEN;
            y_lat   <= OFFSCREEN;
        end else begin
            vblnk_d <= vblnk_in;
            if (vblnk_in && !vblnk_d) begin
                x_lat <= xpos;
                y_lat <= ypos;
            end
        end
    end

    // 13-bit compare keeps x_lat+WIDTH from wrapping back to column 0.
    always_comb begin
        h_ext  = {2'b00, hcount_in};
        v_ext  = {2'b00, vcount_in};
        x_ext  = {1'b0, x_lat};
        y_ext  = {1'b0, y_lat};
        in_win = !hblnk_in && !vblnk_in &&
                 (h_ext >= x_ext) && (h_ext < x_ext + 13'(WIDTH)) &&
                 (v_ext >= y_ext) && (v_ext < y_ext + 13'(HEIGHT));
        col    = hcount_in[5:0] - x_lat[5:0];
        row    = vcount_in[5:0] - y_lat[5:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_1   <= '0;
            vcount_1   <= '0;
            hsync_1    <= 1'b0;
            vsync_1    <= 1'b0;
            hblnk_1    <= 1'b0;
            vblnk_1    <= 1'b0;
            rgb_1      <= '0;
            in_win_1   <= 1'b0;
            pixel_addr <= '0;
        end else begin
            hcount_1   <= hcount_in;
            vcount_1   <= vcount_in;
            hsync_1    <= hsync_in;
            vsync_1    <= vsync_in;
            hblnk_1    <= hblnk_in;
            vblnk_1    <= vblnk_in;
            rgb_1      <= rgb_in;
            in_win_1   <= in_win;
            pixel_addr <= {row, col};
        end
    end

    // ROM data for the stage-1 address is valid here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_1;
            vcount_out <= vcount_1;
            hsync_out  <= hsync_1;
            vsync_out  <= vsync_1;
            hblnk_out  <= hblnk_1;
            vblnk_out  <= vblnk_1;
            rgb_out    <= (in_win_1 && rgb_pixel != TRANSPARENT) ? rgb_pixel : rgb_1;
        end
    end

endmodule

// File: tb/tb_draw_bag.sv
// Self-checking bench for draw_bag: directed scans plus random traffic against
// a frame-level reference model of the sprite overlay.
module tb_draw_bag;

    localparam int W = 48;
    localparam int H = 48;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    wire  [11:0] rgb_pixel;
    logic [11:0] pixel_addr;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    int total = 0;
    int bad   = 0;
    int rom_mode = 0;

    draw_bag dut (
        .clk(clk), .rst(rst),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .rgb_pixel(rgb_pixel), .pixel_addr(pixel_addr),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(logic [11:0] a, int mode);
        if (mode == 0) return 12'h0A5;
        if (mode == 1) return 12'hF0F;
        return (a[0] & a[6]) ? 12'hF0F : (a ^ 12'h5A3);
    endfunction

    assign rgb_pixel = rom_f(pixel_addr, rom_mode);

    // Reference model: latched position plus one pipeline entry in flight.
    int          m_x, m_y;
    bit          m_vd;
    logic [25:0] p_tim;
    bit          p_win;
    logic [11:0] p_addr, p_rgb;

    function automatic logic [25:0] tim_in();
        return {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
    endfunction

    function automatic logic [25:0] tim_out();
        return {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 4095; m_y = 4095; m_vd = 0;
        p_tim = '0; p_win = 0; p_addr = '0; p_rgb = '0;
    endtask

    task automatic cyc();
        int h, v;
        bit win;
        logic [11:0] addr, pix, exp_rgb;
        @(posedge clk);
        pix = rom_f(p_addr, rom_mode);
        exp_rgb = (p_win && pix != 12'hF0F) ? pix : p_rgb;
        h = int'(hcount_in);
        v = int'(vcount_in);
        win = !hblnk_in && !vblnk_in && h >= m_x && h < m_x + W && v >= m_y && v < m_y + H;
        addr = 12'((((v - m_y) & 63) * 64) + ((h - m_x) & 63));
        if (vblnk_in && !m_vd) begin
            m_x = int'(xpos);
            m_y = int'(ypos);
        end
        m_vd = vblnk_in;
        #1;
        check("timing", 64'(tim_out()), 64'(p_tim));
        check("rgb", 64'(rgb_out), 64'(exp_rgb));
        if (win) check("addr", 64'(pixel_addr), 64'(addr));
        p_tim = tim_in(); p_win = win; p_addr = addr; p_rgb = rgb_in;
    endtask

    task automatic drive(int h, int v, bit hs, bit vs, bit hb, bit vb);
        hcount_in = 11'(h); vcount_in = 11'(v);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
        rgb_in = 12'($urandom);
        cyc();
    endtask

    task automatic scan(int v, int h0, int h1);
        for (int h = h0; h <= h1; h++) drive(h, v, 0, 0, 0, 0);
    endtask

    task automatic vblank(int x, int y);
        drive(0, 0, 0, 0, 0, 0);
        xpos = 12'(x); ypos = 12'(y);
        drive(0, 600, 0, 1, 1, 1);
        drive(1, 600, 0, 1, 1, 1);
        xpos = 12'($urandom); ypos = 12'($urandom);
        drive(2, 600, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_inputs();
        hcount_in = 11'($urandom); vcount_in = 11'($urandom);
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
        hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
        rgb_in = 12'($urandom); xpos = 12'($urandom); ypos = 12'($urandom);
    endtask

    task automatic check_zero(string tag);
        check(tag, {tim_out(), rgb_out, pixel_addr}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        rand_inputs();
        model_reset();
        // 1: reset with random inputs, then background pass-through
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rand_inputs();
            #1 check_zero("reset_outs");
        end
        vblnk_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++)
            drive(int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                  1'($urandom), 1'($urandom), 1'($urandom), 0);

        // 2: constant sprite at (100,200) with exact corner addresses
        rom_mode = 0;
        vblank(100, 200);
        drive(100, 200, 0, 0, 0, 0);
        check("addr_top_left", 64'(pixel_addr), 64'h000);
        drive(147, 247, 0, 0, 0, 0);
        check("addr_bot_right", 64'(pixel_addr), 64'hBEF);
        scan(199, 96, 104);
        scan(200, 96, 152);
        scan(247, 96, 152);
        scan(248, 96, 104);

        // 3: transparent ROM shows the background
        rom_mode = 1;
        scan(210, 98, 150);

        // 4: mid-frame position change ignored until next vblank
        rom_mode = 2;
        xpos = 12'd300;
        scan(220, 95, 350);
        scan(247, 95, 350);
        vblank(300, 200);
        scan(220, 95, 350);

        // 5: far-right latch must not wrap; origin latch draws at 0,0
        vblank(4090, 0);
        scan(0, 0, 60);
        scan(0, 2040, 2047);
        vblank(0, 0);
        scan(0, 0, 50);
        scan(47, 0, 3);
        vblank(2030, 1000);
        scan(1010, 2025, 2047);

        // 6: single-clock sync/blank pulses, then reset mid-pulse
        drive(5, 5, 1, 0, 0, 0);
        drive(6, 5, 0, 1, 0, 0);
        drive(7, 5, 0, 0, 1, 0);
        drive(8, 5, 0, 0, 0, 0);
        drive(9, 5, 0, 0, 0, 0);
        drive(10, 5, 0, 0, 0, 0);
        drive(11, 5, 1, 1, 1, 0);
        drive(12, 5, 1, 1, 1, 0);
        check("pulse_hsync_out", 64'(hsync_out), 64'd1);
        #2 rst = 1'b1;
        #1 check_zero("reset_midpulse");
        model_reset();
        @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0;
        drive(13, 5, 0, 0, 0, 0);
        drive(14, 5, 0, 0, 0, 0);

        // random traffic with occasional frame latches
        for (int i = 0; i < 3000; i++) begin
            int h, v;
            bit vb;
            h = (m_x > 2100) ? int'($urandom_range(0, 2047))
                             : int'($urandom_range(m_x > 5 ? m_x - 5 : 0, m_x + 55 > 2047 ? 2047 : m_x + 55));
            v = (m_y > 2100) ? int'($urandom_range(0, 2047))
                             : int'($urandom_range(m_y > 5 ? m_y - 5 : 0, m_y + 55 > 2047 ? 2047 : m_y + 55));
            vb = ($urandom_range(0, 39) == 0);
            xpos = 12'($urandom_range(0, 2100));
            ypos = 12'($urandom_range(0, 1100));
            if (i % 500 == 0) rom_mode = int'($urandom_range(0, 2));
            drive(h, v, 1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), vb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
